// File: rtl/ysyx_23060072_mem_stage_p.sv
// Memory stage: one outstanding bus access with lane steering, load extension and response timeout.
// Optional feature: define YSYX_23060072_MISALIGN_TRAP_EN to trap misaligned half/word/dword accesses.
module ysyx_23060072_mem_stage_p #(
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [XLEN-1:0]     in_pc_i,
    input  logic [XLEN-1:0]     in_wb_data_i,
    input  logic [XLEN-1:0]     in_addr_i,
    input  logic [XLEN-1:0]     in_imm_i,
    input  logic [XLEN-1:0]     in_sdata_i,
    input  logic                in_wb_flag_i,
    input  logic                in_load_i,
    input  logic                in_store_i,
    input  logic                in_signed_i,
    input  logic [1:0]          in_size_i,
    input  logic [RADDR_W-1:0]  in_wb_addr_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic [XLEN-1:0]     mem_req_wdata_o,
    output logic                mem_req_we_o,
    output logic [XLEN/8-1:0]   mem_req_wstrb_o,
    input  logic                mem_rsp_valid_i,
    input  logic                mem_rsp_err_i,
    input  logic [XLEN-1:0]     mem_rsp_rdata_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     out_pc_o,
    output logic [XLEN-1:0]     out_wb_data_o,
    output logic [RADDR_W-1:0]  out_wb_addr_o,
    output logic                out_wb_flag_o,
    output logic                out_load_o,
    output logic                out_err_o,
    output logic                hold_o
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t              state, state_nx;
    logic                init_done;
    logic [CNT_W-1:0]    rsp_cnt;
    logic                timeout_hit;

    logic                accept, mem_op;
    logic [XLEN-1:0]     eff_addr, aligned_addr;
    logic [1:0]          eff_size;
    logic [OFF_W-1:0]    lsb_mask;
    logic [NB-1:0]       size_strb;
    logic [XLEN-1:0]     lane_wdata;
`ifdef YSYX_23060072_MISALIGN_TRAP_EN
    logic                misalign;
`endif

    logic [XLEN-1:0]     op_pc;
    logic [RADDR_W-1:0]  op_wb_addr;
    logic                op_wb_flag, op_load, op_signed;
    logic [1:0]          op_size;
    logic [OFF_W-1:0]    op_off;

    logic [XLEN-1:0]     shifted, ld_val;

    logic                cpl, cpl_flag, cpl_load, cpl_err;
    logic [XLEN-1:0]     cpl_pc, cpl_data;
    logic [RADDR_W-1:0]  cpl_waddr;

    assign in_ready_o      = init_done && (state == IDLE) && (!out_valid_o || out_ready_i);
    assign accept          = in_valid_i && in_ready_o;
    assign mem_op          = in_load_i || in_store_i;
    assign mem_req_valid_o = (state == REQ);
    assign hold_o          = (state != IDLE);
    assign timeout_hit     = (TIMEOUT_CYC != 0) && (rsp_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Request shaping; dword collapses to word on a 32-bit datapath.
    always_comb begin
        eff_addr = in_addr_i + in_imm_i;
        eff_size = ((XLEN == 32) && (in_size_i == 2'b11)) ? 2'b10 : in_size_i;
        lsb_mask   = '0;
        size_strb  = NB'(1);
        lane_wdata = {NB{in_sdata_i[7:0]}};
        case (eff_size)
            2'b01: begin
                lsb_mask   = OFF_W'(1);
                size_strb  = NB'(3);
                lane_wdata = {(NB/2){in_sdata_i[15:0]}};
            end
            2'b10: begin
                lsb_mask   = OFF_W'(3);
                size_strb  = NB'(8'h0F);
                lane_wdata = {(XLEN/32){in_sdata_i[31:0]}};
            end
            2'b11: begin
                lsb_mask   = OFF_W'(7);
                size_strb  = NB'(8'hFF);
                lane_wdata = in_sdata_i;
            end
            default: ;
        endcase
        aligned_addr = eff_addr & ~XLEN'(lsb_mask);
`ifdef YSYX_23060072_MISALIGN_TRAP_EN
        misalign = |(eff_addr[OFF_W-1:0] & lsb_mask);
`endif
    end

    always_comb begin
        shifted = mem_rsp_rdata_i >> {op_off, 3'b000};
        ld_val  = shifted;
        case (op_size)
            2'b00:   ld_val = op_signed ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
            2'b01:   ld_val = op_signed ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
            2'b10:   ld_val = op_signed ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
            default: ;
        endcase
    end

    always_comb begin
        state_nx  = state;
        cpl       = 1'b0;
        cpl_pc    = op_pc;
        cpl_data  = '0;
        cpl_waddr = op_wb_addr;
        cpl_flag  = 1'b0;
        cpl_load  = op_load;
        cpl_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!mem_op) begin
                        cpl       = 1'b1;
                        cpl_pc    = in_pc_i;
                        cpl_data  = in_wb_data_i;
                        cpl_waddr = in_wb_addr_i;
                        cpl_flag  = in_wb_flag_i;
                        cpl_load  = in_load_i;
                    end
`ifdef YSYX_23060072_MISALIGN_TRAP_EN
                    else if (misalign) begin
                        cpl       = 1'b1;
                        cpl_pc    = in_pc_i;
                        cpl_waddr = in_wb_addr_i;
                        cpl_load  = in_load_i;
                        cpl_err   = 1'b1;
                    end
`endif
                    else begin
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready_i) state_nx = RSP;
            end
            RSP: begin
                if (mem_rsp_valid_i) begin
                    cpl      = 1'b1;
                    state_nx = IDLE;
                    if (mem_rsp_err_i) begin
                        cpl_err = 1'b1;
                    end else begin
                        cpl_data = op_load ? ld_val : '0;
                        cpl_flag = op_wb_flag && op_load;
                    end
                end else if (timeout_hit) begin
                    cpl      = 1'b1;
                    cpl_err  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            init_done <= 1'b0;
            rsp_cnt   <= '0;
        end else begin
            state     <= state_nx;
            init_done <= 1'b1;
            rsp_cnt   <= (state == RSP) ? rsp_cnt + CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_addr_o  <= '0;
            mem_req_wdata_o <= '0;
            mem_req_we_o    <= 1'b0;
            mem_req_wstrb_o <= '0;
            op_pc           <= '0;
            op_wb_addr      <= '0;
            op_wb_flag      <= 1'b0;
            op_load         <= 1'b0;
            op_signed       <= 1'b0;
            op_size         <= '0;
            op_off          <= '0;
        end else if ((state == IDLE) && (state_nx == REQ)) begin
            mem_req_addr_o  <= aligned_addr;
            mem_req_wdata_o <= lane_wdata;
            mem_req_we_o    <= in_store_i && !in_load_i;
            mem_req_wstrb_o <= (in_store_i && !in_load_i) ? (size_strb << aligned_addr[OFF_W-1:0]) : '0;
            op_pc           <= in_pc_i;
            op_wb_addr      <= in_wb_addr_i;
            op_wb_flag      <= in_wb_flag_i;
            op_load         <= in_load_i;
            op_signed       <= in_signed_i;
            op_size         <= eff_size;
            op_off          <= aligned_addr[OFF_W-1:0];
        end
    end

    // A new completion always wins over a same-cycle drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o   <= 1'b0;
            out_pc_o      <= '0;
            out_wb_data_o <= '0;
            out_wb_addr_o <= '0;
            out_wb_flag_o <= 1'b0;
            out_load_o    <= 1'b0;
            out_err_o     <= 1'b0;
        end else if (cpl) begin
            out_valid_o   <= 1'b1;
            out_pc_o      <= cpl_pc;
            out_wb_data_o <= cpl_data;
            out_wb_addr_o <= cpl_waddr;
            out_wb_flag_o <= cpl_flag;
            out_load_o    <= cpl_load;
            out_err_o     <= cpl_err;
        end else if (out_ready_i) begin
            out_valid_o   <= 1'b0;
        end
    end

endmodule
